// File: rtl/hazard5_bpred_if.sv
// Decode/execute-side signal bundle for the Hazard5 dynamic branch predictor.
// master = pipeline (decode + execute), slave = predictor.
interface hazard5_bpred_if #(
    parameter int unsigned W_ADDR = 32
) ();
    logic [W_ADDR-1:0] d_pc;
    logic              d_is_branch;
    logic              d_imm_sign;
    logic              d_predict_taken;
    logic              x_update_vld;
    logic [W_ADDR-1:0] x_update_pc;
    logic              x_update_taken;
    logic              bp_clear;
    logic              bp_ready;

    modport master (
        output d_pc, d_is_branch, d_imm_sign,
        output x_update_vld, x_update_pc, x_update_taken,
        output bp_clear,
        input  d_predict_taken, bp_ready
    );

    modport slave (
        input  d_pc, d_is_branch, d_imm_sign,
        input  x_update_vld, x_update_pc, x_update_taken,
        input  bp_clear,
        output d_predict_taken, bp_ready
    );
endinterface

// File: rtl/hazard5_bpred.sv
// Hazard5 branch predictor: saturating-counter table indexed by halfword PC.
// Define HAZARD5_BPRED_BYPASS_EN to forward a same-cycle update to the lookup.
module hazard5_bpred #(
    parameter int unsigned W_ADDR    = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned W_CTR     = 2,
    parameter int unsigned INIT_CTR  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard5_bpred_if.slave   bp
);
    localparam int unsigned      IDX_W    = $clog2(BHT_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BHT_DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [W_CTR-1:0] CTR_INIT = W_CTR'(INIT_CTR);
    localparam logic [W_CTR-1:0] CTR_ONE  = W_CTR'(1);
    localparam logic [W_CTR-1:0] CTR_MAX  = '1;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             bp_ready_q, bp_ready_d;

    // Counter storage has no reset; the clear sequence defines its contents.
    logic [W_CTR-1:0] bht_q [BHT_DEPTH];

    logic [W_ADDR-1:0] d_pc_w, x_pc_w;
    logic [IDX_W-1:0]  d_idx, x_idx;
    logic [W_CTR-1:0]  x_ctr_old, x_ctr_new, d_ctr;
    logic              upd_en;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [W_CTR-1:0]  wr_ctr;
    logic              unused_pc_bits;

    assign d_pc_w         = bp.d_pc;
    assign x_pc_w         = bp.x_update_pc;
    assign d_idx          = d_pc_w[IDX_W:1];
    assign x_idx          = x_pc_w[IDX_W:1];
    assign unused_pc_bits = ^{d_pc_w, x_pc_w};

    always_comb begin
        x_ctr_old = bht_q[x_idx];
        if (bp.x_update_taken) begin
            x_ctr_new = (x_ctr_old == CTR_MAX) ? x_ctr_old : x_ctr_old + CTR_ONE;
        end else begin
            x_ctr_new = (x_ctr_old == '0) ? x_ctr_old : x_ctr_old - CTR_ONE;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        upd_en    = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = clr_idx_q;
        wr_ctr    = CTR_INIT;
        case (state_q)
            ST_CLEAR: begin
                wr_en = 1'b1;
                if (bp.bp_clear) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == IDX_LAST) begin
                    state_d   = ST_RUN;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + IDX_ONE;
                end
            end
            ST_RUN: begin
                if (bp.bp_clear) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end else if (bp.x_update_vld) begin
                    upd_en = 1'b1;
                    wr_en  = 1'b1;
                    wr_idx = x_idx;
                    wr_ctr = x_ctr_new;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        endcase
        bp_ready_d = (state_d == ST_RUN);
    end

    always_comb begin
        d_ctr = bht_q[d_idx];
`ifdef HAZARD5_BPRED_BYPASS_EN
        if (upd_en && (x_idx == d_idx)) begin
            d_ctr = x_ctr_new;
        end
`endif
    end

    assign bp.d_predict_taken = bp.d_is_branch & (bp_ready_q ? d_ctr[W_CTR-1] : bp.d_imm_sign);
    assign bp.bp_ready        = bp_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_idx_q  <= '0;
            bp_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            bp_ready_q <= bp_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            bht_q[wr_idx] <= wr_ctr;
        end
    end
endmodule

// File: tb/tb_hazard5_bpred.sv
// Directed self-checking bench for hazard5_bpred (default parameters):
// an abstract counter-table model checked every cycle, plus literal pins.
module tb_hazard5_bpred;
`ifdef HAZARD5_BPRED_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic rst_n;
    bit   chk_en;
    int   n_cmp;
    int   n_bad;

    hazard5_bpred_if #(.W_ADDR(32)) bp_if ();

    hazard5_bpred #(
        .W_ADDR   (32),
        .BHT_DEPTH(64),
        .W_CTR    (2),
        .INIT_CTR (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bp   (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Abstract model: counters as plain ints, clear as a countdown of cycles.
    int m_ctr [64];
    bit m_ready;
    int m_cnt;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 1) % 64);
    endfunction

    function automatic int sat_step(input int c, input bit tk);
        if (tk) return (c + 1 > 3) ? 3 : c + 1;
        return (c - 1 < 0) ? 0 : c - 1;
    endfunction

    function automatic logic model_pred();
        int c;
        c = m_ctr[idx_of(bp_if.d_pc)];
        if (BYPASS && m_ready && bp_if.x_update_vld && !bp_if.bp_clear &&
            idx_of(bp_if.x_update_pc) == idx_of(bp_if.d_pc))
            c = sat_step(c, bp_if.x_update_taken);
        if (!bp_if.d_is_branch) return 1'b0;
        return m_ready ? (c >= 2) : bp_if.d_imm_sign;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 1'b0;
            m_cnt   = 0;
        end else if (!m_ready) begin
            if (bp_if.bp_clear) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == 64) begin
                    m_ready = 1'b1;
                    foreach (m_ctr[i]) m_ctr[i] = 1;
                end
            end
        end else if (bp_if.bp_clear) begin
            m_ready = 1'b0;
            m_cnt   = 0;
        end else if (bp_if.x_update_vld) begin
            m_ctr[idx_of(bp_if.x_update_pc)] =
                sat_step(m_ctr[idx_of(bp_if.x_update_pc)], bp_if.x_update_taken);
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("bp_ready", bp_if.bp_ready, m_ready);
            check("predict", bp_if.d_predict_taken, model_pred());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic upd(input logic [31:0] pc, input bit tk, input int n);
        repeat (n) begin
            bp_if.x_update_vld   = 1'b1;
            bp_if.x_update_pc    = pc;
            bp_if.x_update_taken = tk;
            tick();
        end
        bp_if.x_update_vld = 1'b0;
        #1;
    endtask

    task automatic look(input logic [31:0] pc, input logic exp, input string name);
        bp_if.d_pc = pc;
        #1;
        check(name, bp_if.d_predict_taken, exp);
        tick();
    endtask

    // 64-cycle clear window; late updates on pc 0x100 must be dropped.
    task automatic expect_clear(input string name);
        for (int c = 0; c < 64; c++) begin
            bp_if.x_update_vld   = (c >= 57 && c < 60);
            bp_if.x_update_pc    = 32'h100;
            bp_if.x_update_taken = 1'b1;
            if (c == 0 || c == 63) begin
                #1;
                check({name, "_ready_low"}, bp_if.bp_ready, 1'b0);
            end
            tick();
        end
        bp_if.x_update_vld = 1'b0;
        #1;
        check({name, "_ready_high"}, bp_if.bp_ready, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        chk_en = 1'b0;
        rst_n = 1'b1;
        bp_if.d_pc = '0;
        bp_if.d_is_branch = 1'b0;
        bp_if.d_imm_sign = 1'b0;
        bp_if.x_update_vld = 1'b0;
        bp_if.x_update_pc = '0;
        bp_if.x_update_taken = 1'b0;
        bp_if.bp_clear = 1'b0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Initial clear: static prediction follows d_imm_sign
        bp_if.d_is_branch = 1'b1;
        bp_if.d_pc = 32'h100;
        for (int c = 0; c < 64; c++) begin
            bp_if.d_imm_sign = c[0];
            #1;
            if (c == 0 || c == 63) check("reset_ready_low", bp_if.bp_ready, 1'b0);
            if (c == 5) check("static_backward", bp_if.d_predict_taken, 1'b1);
            if (c == 6) check("static_forward", bp_if.d_predict_taken, 1'b0);
            tick();
        end
        #1;
        check("reset_ready_high", bp_if.bp_ready, 1'b1);
        bp_if.d_imm_sign = 1'b1;
        look(32'h100, 1'b0, "init_weak_nt");

        bp_if.d_is_branch = 1'b0;
        look(32'h100, 1'b0, "not_branch");
        bp_if.d_is_branch = 1'b1;

        // Training and saturation on pc 0x100
        upd(32'h100, 1'b1, 2);
        check("train_t2", bp_if.d_predict_taken, 1'b1);
        upd(32'h100, 1'b1, 5);
        upd(32'h100, 1'b0, 1);
        check("sat_high_then_nt1", bp_if.d_predict_taken, 1'b1);
        upd(32'h100, 1'b0, 2);
        check("nt3", bp_if.d_predict_taken, 1'b0);
        upd(32'h100, 1'b0, 3);
        upd(32'h100, 1'b1, 1);
        check("sat_low_then_t1", bp_if.d_predict_taken, 1'b0);
        upd(32'h100, 1'b1, 1);
        check("sat_low_then_t2", bp_if.d_predict_taken, 1'b1);

        // Aliasing and index bits
        upd(32'h100, 1'b1, 2);
        look(32'h180, 1'b1, "alias_0x180");
        look(32'h101, 1'b1, "bit0_ignored");
        look(32'h102, 1'b0, "next_index");

        // Clear with simultaneous update, updates during clear dropped
        bp_if.bp_clear = 1'b1;
        bp_if.x_update_vld = 1'b1;
        bp_if.x_update_pc = 32'h100;
        bp_if.x_update_taken = 1'b1;
        tick();
        bp_if.bp_clear = 1'b0;
        bp_if.x_update_vld = 1'b0;
        expect_clear("midrun_clear");
        for (int i = 0; i < 64; i++) begin
            look(32'(i * 2 + (i % 2)), 1'b0, "post_clear_sweep");
        end

        // Same-cycle update and lookup on pc 0x100, ctr 1, taken
        bp_if.d_pc = 32'h100;
        bp_if.x_update_vld = 1'b1;
        bp_if.x_update_pc = 32'h100;
        bp_if.x_update_taken = 1'b1;
        #1;
        check("same_cycle_lookup", bp_if.d_predict_taken, BYPASS);
        tick();
        bp_if.x_update_vld = 1'b0;
        #1;
        check("next_cycle_lookup", bp_if.d_predict_taken, 1'b1);

        // bp_clear during CLEAR restarts the sequence
        bp_if.bp_clear = 1'b1;
        tick();
        bp_if.bp_clear = 1'b0;
        repeat (10) tick();
        bp_if.bp_clear = 1'b1;
        tick();
        bp_if.bp_clear = 1'b0;
        expect_clear("restart_clear");

        // Async reset at clr_idx = 30
        bp_if.bp_clear = 1'b1;
        tick();
        bp_if.bp_clear = 1'b0;
        repeat (30) tick();
        #1 rst_n = 1'b0;
        #1;
        check("reset_midclear_ready", bp_if.bp_ready, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        expect_clear("after_reset_midclear");

        // Async reset during RUN discards training
        upd(32'h100, 1'b1, 2);
        check("pre_reset_trained", bp_if.d_predict_taken, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_run_ready", bp_if.bp_ready, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        expect_clear("after_reset_run");
        look(32'h100, 1'b0, "reset_restores_init");

        repeat (2) tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard5_bpred.md
# hazard5_bpred

Dynamic branch predictor for the Hazard5 decode stage. It replaces fixed "backward-taken" prediction with a parametrised table of saturating counters, indexed by halfword PC. Decode reads a prediction combinationally for the instruction in D. Execute writes back resolved outcomes. A sequenced table clear runs after reset and on request, and static prediction covers the clear window.

## Interface
Parameters:
- W_ADDR, 32, PC width.
- BHT_DEPTH, 64, number of counters; power of 2, ≥2. IDX_W = log2(BHT_DEPTH).
- W_CTR, 2, counter width, ≥1.
- INIT_CTR, 1, value written to every counter by a clear; must be < 2^W_CTR.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- d_pc  in  W_ADDR  PC of the instruction in D.
- d_is_branch  in  1  D holds a conditional branch and is not starved.
- d_imm_sign  in  1  sign bit of the branch offset (1 = backward).
- d_predict_taken  out  1  prediction for D; combinational.
- x_update_vld  in  1  a branch resolved in X this cycle.
- x_update_pc  in  W_ADDR  PC of the resolved branch.
- x_update_taken  in  1  resolved direction.
- bp_clear  in  1  single-cycle request to reinitialise the table (e.g. fence.i).
- bp_ready  out  1  table valid; dynamic prediction in use.

## Operation
- Index = pc[IDX_W:1]. Bit 0 is ignored (halfword granularity for the C extension). Aliasing is permitted.
- Table storage is a flop array with no reset. Contents are defined only by the clear sequence.
- FSM states:
  - CLEAR: clr_idx increments by 1 each cycle and writes INIT_CTR to table[clr_idx]. When clr_idx = BHT_DEPTH-1, the next state is RUN and clr_idx returns to 0.
  - RUN: if bp_clear = 1, the next state is CLEAR with clr_idx = 0.
- Reset state is CLEAR, clr_idx = 0, bp_ready = 0.
- bp_ready is registered: 1 iff state = RUN.
- Prediction:
  - d_predict_taken = d_is_branch & (bp_ready ? table[idx(d_pc)][W_CTR-1] : d_imm_sign).
  - When d_is_branch = 0, the output is 0 regardless of state.
- Update, in RUN with x_update_vld = 1:
  - taken: counter = min(ctr+1, 2^W_CTR-1).
  - not taken: counter = max(ctr-1, 0).
  - Arithmetic is W_CTR bits wide and never wraps.
- Updates arriving in CLEAR are discarded.
- bp_clear in CLEAR restarts the sequence: clr_idx = 0 next cycle.
- bp_clear together with x_update_vld in RUN: the update is discarded and the clear starts.
- Reset mid-clear or mid-run returns to CLEAR at clr_idx = 0. No other state survives.

## Timing
- Lookup latency is 0 cycles: the table is read asynchronously from d_pc.
- Updates are written at the posedge where x_update_vld = 1 and become visible to lookups on the next cycle.
- A clear lasts exactly BHT_DEPTH cycles:
  - bp_ready falls on the edge after bp_clear is sampled.
  - bp_ready rises BHT_DEPTH cycles later.
  - After reset deassertion, bp_ready rises on the BHT_DEPTH-th clk edge.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update value, unless bypass is enabled (see Configuration).
- Only one update per cycle. The d_* inputs and x_* inputs are independent and may be active in the same cycle.

## Configuration
- Macro HAZARD5_BPRED_BYPASS_EN.
- Defined: when x_update_vld, in RUN and with no bp_clear in the same cycle, hits the same index as d_pc, d_predict_taken uses the post-update counter MSB. Costs one index comparator and a mux on the lookup path.
- Undefined: no bypass; the lookup sees the old value, and the new value appears from the next cycle.

## Test plan
All scenarios use default parameters.
- Reset, then hold d_is_branch = 1:
  - bp_ready = 0 for cycles 0..63 and 1 from cycle 64.
  - During the clear, d_imm_sign = 1 gives prediction 1 and d_imm_sign = 0 gives 0.
  - After the clear, pc 0x100 predicts 0 (INIT_CTR = 1).
- Training on pc 0x100:
  - Two taken updates (ctr 1 → 3): prediction 1.
  - Five more taken updates: ctr stays 3.
  - One not-taken update (ctr 2): prediction still 1.
  - Two more not-taken updates (ctr 0): prediction 0.
  - Further not-taken updates: ctr stays 0.
- Aliasing and index bits:
  - Train pc 0x100 taken ×2, then pc 0x180 predicts 1 (same index), and pc 0x101 predicts 1 (bit 0 ignored).
  - pc 0x102 predicts 0.
- Clear mid-run:
  - After training, pulse bp_clear with a simultaneous update: bp_ready = 0 next cycle for 64 cycles, and the update is discarded.
  - Updates issued during the clear are also discarded.
  - Afterwards every index predicts 0.
- Same-cycle update and lookup on pc 0x100 at ctr 1, taken:
  - Without the macro: prediction 0 this cycle, 1 next cycle.
  - With HAZARD5_BPRED_BYPASS_EN: prediction 1 this cycle.
- Async reset asserted at clr_idx = 30 and during RUN: on release, bp_ready = 0 and a full 64-cycle clear is observed.
